// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath (slave).
// The master drives the enables and selects; the slave returns the IR fields and the memory ready handshake.
interface mc_control_fsm_if #(
  parameter int ALU_W = 3,
  parameter int ST_W  = 4
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [ALU_W-1:0] alu_op;
  logic             alu_slt;
  logic             illegal;
  logic [ST_W-1:0]  dbg_state;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, alu_slt, illegal, dbg_state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, alu_slt, illegal, dbg_state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle MIPS-subset CPU; controls are registered from the next state.
// Stalls in IF/MR/MW until mem_ready; only the fetch strobes (ir_write, pc_write) follow mem_ready directly.
module mc_control_fsm #(
  parameter int ALU_W = 3,
  parameter int ST_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [ST_W-1:0] {
    S_IF  = ST_W'(0),  S_ID = ST_W'(1),  S_MA = ST_W'(2),  S_MR = ST_W'(3),
    S_WL  = ST_W'(4),  S_MW = ST_W'(5),  S_RX = ST_W'(6),  S_RW = ST_W'(7),
    S_BR  = ST_W'(8),  S_JP = ST_W'(9),  S_IX = ST_W'(10), S_IW = ST_W'(11),
    S_ERR = ST_W'(15)
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             fetch;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [ALU_W-1:0] alu_op;
    logic             alu_slt;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   run;

  function automatic logic funct_ok(logic [5:0] fn);
    case (fn)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode(state_e s, logic [5:0] op, logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
      S_ID: c.alu_src_b = 2'b11;
      S_MA: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MR: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_WL: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MW: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_RX: begin
        c.alu_src_a = 1'b1;
        case (fn)
          6'h22:   c.alu_op = ALU_W'(3'b001);
          6'h24:   c.alu_op = ALU_W'(3'b010);
          6'h25:   c.alu_op = ALU_W'(3'b011);
          6'h26:   c.alu_op = ALU_W'(3'b100);
          6'h27:   c.alu_op = ALU_W'(3'b101);
          6'h2A:   begin c.alu_op = ALU_W'(3'b001); c.alu_slt = 1'b1; end
          default: c.alu_op = ALU_W'(3'b000);
        endcase
      end
      S_RW: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BR: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.alu_op        = (op == OP_BNE) ? ALU_W'(3'b111) : ALU_W'(3'b110);
      end
      S_JP: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_IX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_IW: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        case (bus.opcode)
          OP_RTYPE:      state_d = S_RX;
          OP_LW, OP_SW:  state_d = S_MA;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:          state_d = S_JP;
          OP_ADDI:       state_d = S_IX;
          default:       state_d = S_ERR;
        endcase
      end
      S_MA: state_d = (bus.opcode == OP_LW) ? S_MR : S_MW;
      S_MR: if (bus.mem_ready) state_d = S_WL;
      S_MW: if (bus.mem_ready) state_d = S_IF;
      S_RX: state_d = funct_ok(bus.funct) ? S_RW : S_ERR;
      S_IX: state_d = S_IW;
      S_WL, S_RW, S_BR, S_JP, S_IW: state_d = S_IF;
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Controls are registered from state_d so they line up with state_q without a decode stage after the flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      ctrl_q    <= decode(S_IF, bus.opcode, bus.funct);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, bus.opcode, bus.funct);
      if (state_d == S_ERR) illegal_q <= 1'b1;
    end
  end

  assign run = ~rst;

  assign bus.pc_write      = run & (ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready));
  assign bus.ir_write      = run & ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_write_cond = run & ctrl_q.pc_write_cond;
  assign bus.i_or_d        = run & ctrl_q.i_or_d;
  assign bus.mem_read      = run & ctrl_q.mem_read;
  assign bus.mem_write     = run & ctrl_q.mem_write;
  assign bus.mem_to_reg    = run & ctrl_q.mem_to_reg;
  assign bus.reg_dst       = run & ctrl_q.reg_dst;
  assign bus.reg_write     = run & ctrl_q.reg_write;
  assign bus.alu_src_a     = run & ctrl_q.alu_src_a;
  assign bus.alu_src_b     = {2{run}} & ctrl_q.alu_src_b;
  assign bus.pc_source     = {2{run}} & ctrl_q.pc_source;
  assign bus.alu_op        = {ALU_W{run}} & ctrl_q.alu_op;
  assign bus.alu_slt       = run & ctrl_q.alu_slt;
  assign bus.illegal       = run & illegal_q;
  assign bus.dbg_state     = run ? state_q : '0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction stream against a per-instruction state-sequence model; a negedge monitor
// pops one expected control word per cycle from the scoreboard queue and compares it with the DUT.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.ALU_W(3), .ST_W(4)) bus ();
  mc_control_fsm #(.ALU_W(3), .ST_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05, JMP = 6'h02, ADDI = 6'h08;

  logic [5:0] rfn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [2:0] raop [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
  logic       rslt [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [22:0] exp_q [$];
  int          st_q  [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;
  logic [22:0] e_v, a_v;
  int          e_st;

  function automatic bit fn_valid(logic [5:0] fn);
    for (int i = 0; i < 7; i++) if (fn == rfn[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit op_legal(logic [5:0] op);
    return op == 6'h00 || op == LW || op == SW || op == BEQ || op == BNE || op == JMP || op == ADDI;
  endfunction

  // Expected control word for one cycle spent in state st (numbering as in the state table).
  function automatic logic [22:0] model(int st, bit mr, logic [5:0] op, logic [5:0] fn, bit r);
    logic pcw = 0, pcc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, slt = 0, ill = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] aop = 0;
    logic [3:0] s4 = 4'(st);
    if (r) return '0;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin
        sa = 1;
        for (int i = 0; i < 7; i++) if (fn == rfn[i]) begin aop = raop[i]; slt = rslt[i]; end
      end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; pcc = 1; ps = 2'b01; aop = (op == BNE) ? 3'b111 : 3'b110; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      15: ill = 1;
      default: ;
    endcase
    return {s4, ill, pcw, pcc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ps, aop, slt};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_v  = exp_q.pop_front();
      e_st = st_q.pop_front();
      a_v  = {bus.dbg_state, bus.illegal, bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.pc_source, bus.alu_op, bus.alu_slt};
      total++;
      if (a_v !== e_v) begin
        bad++;
        $display("FAIL ctrl cycle=%0d model_state=%0d got=%h want=%h", cyc_n, e_st, a_v, e_v);
      end
    end
    cyc_n++;
  end

  task automatic cyc(input int st, input bit mr, input logic [5:0] op, input logic [5:0] fn, input bit r);
    rst           = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.funct     = fn;
    exp_q.push_back(model(st, mr, op, fn, r));
    st_q.push_back(st);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int st, input int w, input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < w; i++) cyc(st, 1'b0, op, fn, 1'b0);
    cyc(st, 1'b1, op, fn, 1'b0);
  endtask

  task automatic err_tail(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 3; i++) cyc(15, 1'($urandom), op, fn, 1'b0);
    cyc(15, 1'($urandom), op, fn, 1'b1);
  endtask

  // One instruction; a wait count of -1 picks 0..2 stall cycles at random.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int if_w, input int mem_w, input bit abort);
    int w;
    w = (if_w < 0) ? int'($urandom_range(0, 2)) : if_w;
    for (int i = 0; i < w; i++) cyc(0, 1'b0, 6'($urandom), 6'($urandom), 1'b0);
    cyc(0, 1'b1, 6'($urandom), 6'($urandom), 1'b0);
    cyc(1, 1'($urandom), op, fn, 1'b0);
    if (op == 6'h00) begin
      cyc(6, 1'($urandom), op, fn, 1'b0);
      if (fn_valid(fn)) cyc(7, 1'($urandom), op, fn, 1'b0);
      else err_tail(op, fn);
    end else if (op == LW || op == SW) begin
      cyc(2, 1'($urandom), op, fn, 1'b0);
      w = (mem_w < 0) ? int'($urandom_range(0, 2)) : mem_w;
      if (abort) begin
        for (int i = 0; i < w; i++) cyc(5, 1'b0, op, fn, 1'b0);
        cyc(5, 1'b0, op, fn, 1'b1);
        return;
      end
      hold((op == LW) ? 3 : 5, w, op, fn);
      if (op == LW) cyc(4, 1'($urandom), op, fn, 1'b0);
    end else if (op == BEQ || op == BNE) begin
      cyc(8, 1'($urandom), op, fn, 1'b0);
    end else if (op == JMP) begin
      cyc(9, 1'($urandom), op, fn, 1'b0);
    end else if (op == ADDI) begin
      cyc(10, 1'($urandom), op, fn, 1'b0);
      cyc(11, 1'($urandom), op, fn, 1'b0);
    end else begin
      err_tail(op, fn);
    end
  endtask

  initial begin
    logic [5:0] op;
    int k;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    @(posedge clk);
    #1;
    cyc(0, 1'b0, 6'h00, 6'h00, 1'b1);
    cyc(0, 1'b0, 6'h00, 6'h00, 1'b1);

    instr(6'h00, 6'h20, 0, 0, 1'b0);
    instr(6'h00, 6'h2A, 0, 0, 1'b0);
    instr(6'h00, 6'h22, 0, 0, 1'b0);
    instr(LW, 6'h11, 0, 2, 1'b0);
    instr(BNE, 6'h00, 0, 0, 1'b0);
    instr(JMP, 6'h3F, 0, 0, 1'b0);
    instr(6'h3F, 6'h20, 0, 0, 1'b0);
    instr(6'h00, 6'h01, 0, 0, 1'b0);
    instr(SW, 6'h00, 0, 1, 1'b1);
    instr(SW, 6'h00, 1, 0, 1'b1);
    instr(ADDI, 6'h05, 2, 0, 1'b0);
    instr(BEQ, 6'h00, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 19);
      case (k)
        0, 1, 2, 3, 4, 5, 18, 19: instr(6'h00, rfn[$urandom_range(0, 6)], -1, -1, 1'b0);
        6:      instr(6'h00, 6'($urandom), -1, -1, 1'b0);
        7, 8:   instr(LW, 6'($urandom), -1, -1, 1'b0);
        9, 10:  instr(SW, 6'($urandom), -1, -1, 1'b0);
        11:     instr(BEQ, 6'($urandom), -1, -1, 1'b0);
        12:     instr(BNE, 6'($urandom), -1, -1, 1'b0);
        13:     instr(JMP, 6'($urandom), -1, -1, 1'b0);
        14, 15: instr(ADDI, 6'($urandom), -1, -1, 1'b0);
        16: begin
          op = 6'($urandom);
          while (op_legal(op)) op = 6'($urandom);
          instr(op, 6'($urandom), -1, -1, 1'b0);
        end
        default: instr(SW, 6'($urandom), -1, -1, 1'b1);
      endcase
    end

    cyc(0, 1'b0, 6'h00, 6'h00, 1'b0);
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete, total=%0d", total);
    $fatal(1, "watchdog expired");
  end
endmodule
